// File: rtl/packer_nx.sv
// packer_nx: narrow-to-wide packer. Collects LANES accepted beats of DATA_W
// bits into one DATA_W*LANES word, first beat in the most-significant lane.
// Beats presented with valid_in low are skipped, not zero-padded.
// The finished word sits in a one-word output slot under ready_out backpressure.
// Optional feature macro: PACKER_FLUSH_EN. When it is defined, flush can emit
// a partial word, and keep_out marks the filled lanes.
module packer_nx #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic                     flush,
  output logic [DATA_W*LANES-1:0]  data_out,
  output logic [LANES-1:0]         keep_out,
  output logic                     valid_out,
  input  logic                     ready_out
);

  localparam int WORD_W = DATA_W * LANES;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] asm_data;
  logic [LANES-1:0]  asm_keep;

  logic              slot_free;
  logic              acc;
  logic              last_beat;
  logic              full_emit;
  logic              flush_emit;
  logic              load;
  logic [WORD_W-1:0] beat_data;
  logic [LANES-1:0]  beat_keep;
  logic [WORD_W-1:0] merged_data;
  logic [LANES-1:0]  merged_keep;

  assign slot_free = !valid_out || ready_out;
  assign last_beat = (cnt == LAST);
  assign acc       = valid_in && ready_in;
  assign full_emit = acc && last_beat;
  assign load      = full_emit || flush_emit;

`ifdef PACKER_FLUSH_EN
  logic flush_pend;

  // A flush is pending if it would emit. This test looks at valid_in rather
  // than acc, so ready_in does not feed back on itself.
  assign flush_pend = flush && ((cnt != '0) || valid_in);

  // Stall the input whenever the next edge would need the output slot and
  // the slot cannot take a word.
  assign ready_in = !reset && !(last_beat && !slot_free) && !(flush_pend && !slot_free);

  // A flush that coincides with a completing beat is just a normal full emit.
  assign flush_emit = flush && slot_free && ((cnt != '0) || acc) && !full_emit;
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign ready_in     = !reset && !(last_beat && !slot_free);
  assign flush_emit   = 1'b0;
`endif

  // Place the current beat in lane cnt, then merge it with the assembled lanes.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cnt == CNT_W'(k)) begin
        beat_data[WORD_W-1-DATA_W*k -: DATA_W] = data_in;
        beat_keep[LANES-1-k]                   = 1'b1;
      end
    end
    merged_data = asm_data | (acc ? beat_data : '0);
    merged_keep = asm_keep | (acc ? beat_keep : '0);
  end

  // Beat counter and assembly register. Both clear on any emit.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else if (load) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else if (acc) begin
      cnt      <= cnt + 1'b1;
      asm_data <= merged_data;
      asm_keep <= merged_keep;
    end
  end

  // Output slot. A pop and a reload in the same cycle give back-to-back words.
  // The slot holds while it is full and the consumer is stalled.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      data_out  <= '0;
      keep_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= merged_data;
      keep_out  <= flush_emit ? merged_keep : '1;
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packer_nx.sv
// Directed testbench for packer_nx with default parameters (8-bit beats, 4 lanes).
// Scenario 4 applies to the PACKER_FLUSH_EN build.
// Scenario 6 applies to the default build.
module tb_packer_nx;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_in;
  logic        flush;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_out;
  logic        ready_out;

  int errs   = 0;
  int checks = 0;

  packer_nx #(.DATA_W(8), .LANES(4)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .flush     (flush),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  // Present one beat for a single edge.
  task automatic beat(input logic [7:0] d);
    data_in  = d;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_out = 1'b1; data_in = '0;
    tick(); tick();
    chk("rst_data", data_out, 32'h0);
    chk("rst_keep", keep_out, 4'h0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready_in", ready_in, 1'b1);

    // 1: four consecutive beats
    beat(8'h2F); beat(8'h5E); beat(8'h8D);
    chk("s1_no_early_valid", valid_out, 1'b0);
    beat(8'hBC);
    chk("s1_valid", valid_out, 1'b1);
    chk("s1_data", data_out, 32'h2F5E8DBC);
    chk("s1_keep", keep_out, 4'hF);
    tick();
    chk("s1_one_cycle", valid_out, 1'b0);

    // 2: gap of three idle cycles between beats 2 and 3
    beat(8'h2F); beat(8'h5E);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_gap_valid", valid_out, 1'b0);
    end
    beat(8'h8D);
    chk("s2_pre_valid", valid_out, 1'b0);
    beat(8'hBC);
    chk("s2_valid", valid_out, 1'b1);
    chk("s2_data", data_out, 32'h2F5E8DBC);
    tick();

    // 3: backpressure
    beat(8'h2F); beat(8'h5E); beat(8'h8D);
    ready_out = 1'b0;
    beat(8'hBC);
    chk("s3_word1", data_out, 32'h2F5E8DBC);
    for (int i = 1; i <= 3; i++) begin
      data_in  = 8'(i);
      valid_in = 1'b1;
      #1;
      chk("s3_ready_in_hi", ready_in, 1'b1);
      tick();
    end
    data_in = 8'h04;
    #1;
    chk("s3_ready_in_lo", ready_in, 1'b0);
    chk("s3_hold_data", data_out, 32'h2F5E8DBC);
    tick();
    chk("s3_hold_data2", data_out, 32'h2F5E8DBC);
    chk("s3_hold_keep", keep_out, 4'hF);
    chk("s3_hold_valid", valid_out, 1'b1);
    chk("s3_still_stalled", ready_in, 1'b0);
    ready_out = 1'b1;
    #1;
    chk("s3_ready_in_rise", ready_in, 1'b1);
    tick();
    chk("s3_word2_valid", valid_out, 1'b1);
    chk("s3_word2", data_out, 32'h01020304);
    beat(8'h05);
    chk("s3_popped", valid_out, 1'b0);
    beat(8'h06); beat(8'h07);
    chk("s3_partial", valid_out, 1'b0);
    beat(8'h08);
    chk("s3_word3", data_out, 32'h05060708);
    chk("s3_word3_valid", valid_out, 1'b1);
    tick();

    // 5: reset mid-word discards the partial word
    beat(8'h55); beat(8'h66);
    reset = 1'b1;
    tick();
    chk("s5_rst_valid", valid_out, 1'b0);
    chk("s5_rst_data", data_out, 32'h0);
    chk("s5_rst_keep", keep_out, 4'h0);
    chk("s5_rst_ready_in", ready_in, 1'b0);
    reset = 1'b0;
    beat(8'hA0); beat(8'hA1); beat(8'hA2);
    chk("s5_no_stale_emit", valid_out, 1'b0);
    beat(8'hA3);
    chk("s5_data", data_out, 32'hA0A1A2A3);
    chk("s5_keep", keep_out, 4'hF);
    tick();

`ifdef PACKER_FLUSH_EN
    // 4: flush of a partial word
    beat(8'h11); beat(8'h22);
    flush = 1'b1;
    tick();
    chk("s4_flush_valid", valid_out, 1'b1);
    chk("s4_flush_data", data_out, 32'h11220000);
    chk("s4_flush_keep", keep_out, 4'b1100);
    flush = 1'b0;
    tick();
    chk("s4_after_valid", valid_out, 1'b0);
    flush = 1'b1;
    tick();
    chk("s4_empty_flush", valid_out, 1'b0);
    tick();
    chk("s4_empty_flush2", valid_out, 1'b0);
    flush = 1'b0;
    beat(8'h33); beat(8'h44); beat(8'h55); beat(8'h66);
    chk("s4_realign", data_out, 32'h33445566);
    chk("s4_realign_keep", keep_out, 4'hF);
    tick();
`else
    // 6: flush is ignored without the flush feature
    beat(8'h11); beat(8'h22);
    flush = 1'b1;
    tick();
    chk("s6_no_emit", valid_out, 1'b0);
    tick();
    chk("s6_no_emit2", valid_out, 1'b0);
    beat(8'h33); beat(8'h44);
    chk("s6_valid", valid_out, 1'b1);
    chk("s6_data", data_out, 32'h11223344);
    chk("s6_keep", keep_out, 4'hF);
    flush = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
